// File: rtl/wb_pkg.sv
// Shared encodings for the write-back stage: result-source selects, load
// sizes, FSM state type and the captured-load record.
package wb_pkg;

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_LOAD = 2'd1;
  localparam logic [1:0] WB_SEL_PC4  = 2'd2;
  localparam logic [1:0] WB_SEL_CSR  = 2'd3;

  localparam logic [1:0] LOAD_BYTE   = 2'd0;
  localparam logic [1:0] LOAD_HALF   = 2'd1;
  localparam logic [1:0] LOAD_WORD   = 2'd2;
  localparam logic [1:0] LOAD_DOUBLE = 2'd3;

  typedef enum logic {IDLE, WAIT_LOAD} wb_state_e;

  // Attributes of a load parked while the data cache is late.
  typedef struct packed {
    logic [1:0] size;
    logic       is_unsigned;
    logic       reg_write;
  } ld_cap_t;

endpackage

// File: rtl/write_back_unit_if.sv
// Write-back stage bus: MEM-stage request, data-cache response and the
// register-file write / forwarding port.
//   slave  : view taken by write_back_unit
//   master : view taken by the driver (MEM stage / bench)
interface write_back_unit_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      IN_VALID;
  logic                      IN_READY;
  logic [DATA_WIDTH-1:0]     ALU_OUT_IN;
  logic [DATA_WIDTH-1:0]     PC_PLUS_4_IN;
  logic [DATA_WIDTH-1:0]     CSR_DATA_IN;
  logic [1:0]                WB_SELECT_IN;
  logic [1:0]                LOAD_SIZE_IN;
  logic                      LOAD_UNSIGNED_IN;
  logic                      REG_WRITE_IN;
  logic [REG_ADDR_WIDTH-1:0] RD_ADDR_IN;
  logic [DATA_WIDTH-1:0]     DATA_CACHE_OUT_DATA;
  logic                      DATA_CACHE_READY;
  logic                      REG_WRITE_EN_OUT;
  logic [REG_ADDR_WIDTH-1:0] RD_ADDR_OUT;
  logic [DATA_WIDTH-1:0]     RD_DATA_OUT;
  logic                      STALL_OUT;
  logic                      MISALIGNED_OUT;

  modport slave (
    input  IN_VALID, ALU_OUT_IN, PC_PLUS_4_IN, CSR_DATA_IN, WB_SELECT_IN,
           LOAD_SIZE_IN, LOAD_UNSIGNED_IN, REG_WRITE_IN, RD_ADDR_IN,
           DATA_CACHE_OUT_DATA, DATA_CACHE_READY,
    output IN_READY, REG_WRITE_EN_OUT, RD_ADDR_OUT, RD_DATA_OUT,
           STALL_OUT, MISALIGNED_OUT
  );

  modport master (
    output IN_VALID, ALU_OUT_IN, PC_PLUS_4_IN, CSR_DATA_IN, WB_SELECT_IN,
           LOAD_SIZE_IN, LOAD_UNSIGNED_IN, REG_WRITE_IN, RD_ADDR_IN,
           DATA_CACHE_OUT_DATA, DATA_CACHE_READY,
    input  IN_READY, REG_WRITE_EN_OUT, RD_ADDR_OUT, RD_DATA_OUT,
           STALL_OUT, MISALIGNED_OUT
  );
endinterface

// File: rtl/write_back_unit_load_aligner.sv
// load_aligner: combinational load-data extractor.
//   raw_data    : aligned word from the data cache
//   offset      : byte offset within that word
//   size        : LOAD_BYTE/HALF/WORD/DOUBLE
//   is_unsigned : 1 zero-extend, 0 sign-extend
//   ext_data    : extracted, extended value
//   misaligned  : access crosses its natural alignment (or is too wide)
module load_aligner
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int OFFSET_WIDTH = $clog2(DATA_WIDTH/8)
) (
  input  logic [DATA_WIDTH-1:0]   raw_data,
  input  logic [OFFSET_WIDTH-1:0] offset,
  input  logic [1:0]              size,
  input  logic                    is_unsigned,
  output logic [DATA_WIDTH-1:0]   ext_data,
  output logic                    misaligned
);
  logic [DATA_WIDTH-1:0] shifted;

  // Bring the addressed byte lane down to bit 0.
  assign shifted = raw_data >> {offset, 3'b000};

  // Size casts of a $signed operand sign-extend; of an unsigned one, zero-extend.
  always_comb begin
    ext_data   = shifted;
    misaligned = 1'b0;
    case (size)
      LOAD_BYTE: begin
        ext_data = is_unsigned ? DATA_WIDTH'(shifted[7:0])
                               : DATA_WIDTH'($signed(shifted[7:0]));
      end
      LOAD_HALF: begin
        ext_data   = is_unsigned ? DATA_WIDTH'(shifted[15:0])
                                 : DATA_WIDTH'($signed(shifted[15:0]));
        misaligned = offset[0];
      end
      LOAD_WORD: begin
        ext_data   = is_unsigned ? DATA_WIDTH'(shifted[31:0])
                                 : DATA_WIDTH'($signed(shifted[31:0]));
        misaligned = (offset[1:0] != 2'd0);
      end
      default: begin
        // Double: only legal, aligned, on a 64-bit datapath.
        ext_data   = shifted;
        misaligned = (DATA_WIDTH != 64) || (offset != '0);
      end
    endcase
  end
endmodule

// File: rtl/write_back_unit.sv
// write_back_unit: registered write-back stage.
//   CLK, RST : clock, async active-high reset
//   bus      : MEM request (IN_*), data-cache response (DATA_CACHE_*),
//              register-file write port / forwarding value (RD_*, REG_WRITE_EN_OUT),
//              STALL_OUT and MISALIGNED_OUT status.
// Results land one edge after completion. A load whose cache data is not
// ready at accept is parked in WAIT_LOAD with its attributes captured.
module write_back_unit
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int OFFSET_WIDTH   = $clog2(DATA_WIDTH/8)
) (
  input logic              CLK,
  input logic              RST,
  write_back_unit_if.slave bus
);
  wb_state_e                 state;
  ld_cap_t                   cap;
  logic [OFFSET_WIDTH-1:0]   cap_off;
  logic [REG_ADDR_WIDTH-1:0] cap_rd;

  logic                      wen_q, mis_q;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_q;
  logic [DATA_WIDTH-1:0]     rd_data_q;

  logic idle, accept, sel_load, done;
  logic [OFFSET_WIDTH-1:0]   al_off;
  logic [1:0]                al_size;
  logic                      al_uns, al_mis;
  logic [DATA_WIDTH-1:0]     al_data, result;
  logic [REG_ADDR_WIDTH-1:0] done_rd;
  logic                      done_rw, done_ld;

  assign idle     = (state == IDLE);
  assign accept   = bus.IN_VALID && idle;
  assign sel_load = (bus.WB_SELECT_IN == WB_SEL_LOAD);

  assign bus.IN_READY  = idle;
  assign bus.STALL_OUT = !idle || (bus.IN_VALID && sel_load && !bus.DATA_CACHE_READY);

  // Live inputs drive the aligner in IDLE; the parked copy in WAIT_LOAD.
  assign al_off  = idle ? bus.ALU_OUT_IN[OFFSET_WIDTH-1:0] : cap_off;
  assign al_size = idle ? bus.LOAD_SIZE_IN     : cap.size;
  assign al_uns  = idle ? bus.LOAD_UNSIGNED_IN : cap.is_unsigned;

  load_aligner #(.DATA_WIDTH(DATA_WIDTH), .OFFSET_WIDTH(OFFSET_WIDTH)) u_aligner (
    .raw_data    (bus.DATA_CACHE_OUT_DATA),
    .offset      (al_off),
    .size        (al_size),
    .is_unsigned (al_uns),
    .ext_data    (al_data),
    .misaligned  (al_mis)
  );

  always_comb begin
    done    = idle ? (accept && (!sel_load || bus.DATA_CACHE_READY)) : bus.DATA_CACHE_READY;
    done_ld = idle ? sel_load : 1'b1;
    done_rd = idle ? bus.RD_ADDR_IN   : cap_rd;
    done_rw = idle ? bus.REG_WRITE_IN : cap.reg_write;
    result  = al_data;
    if (idle) begin
      case (bus.WB_SELECT_IN)
        WB_SEL_ALU: result = bus.ALU_OUT_IN;
        WB_SEL_PC4: result = bus.PC_PLUS_4_IN;
        WB_SEL_CSR: result = bus.CSR_DATA_IN;
        default:    result = al_data;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      cap       <= '0;
      cap_off   <= '0;
      cap_rd    <= '0;
      wen_q     <= 1'b0;
      mis_q     <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      wen_q <= 1'b0;
      mis_q <= 1'b0;
      case (state)
        IDLE: if (accept && sel_load && !bus.DATA_CACHE_READY) begin
          state           <= WAIT_LOAD;
          cap.size        <= bus.LOAD_SIZE_IN;
          cap.is_unsigned <= bus.LOAD_UNSIGNED_IN;
          cap.reg_write   <= bus.REG_WRITE_IN;
          cap_off         <= bus.ALU_OUT_IN[OFFSET_WIDTH-1:0];
          cap_rd          <= bus.RD_ADDR_IN;
        end
        default: if (bus.DATA_CACHE_READY) state <= IDLE;
      endcase
      if (done) begin
        rd_addr_q <= done_rd;
        rd_data_q <= result;
        // A misaligned load still retires but never writes rd.
        mis_q     <= done_ld && al_mis;
        wen_q     <= done_rw && (done_rd != '0) && !(done_ld && al_mis);
      end
    end
  end

  assign bus.REG_WRITE_EN_OUT = wen_q;
  assign bus.MISALIGNED_OUT   = mis_q;
  assign bus.RD_ADDR_OUT      = rd_addr_q;
  assign bus.RD_DATA_OUT      = rd_data_q;
endmodule

// File: doc/write_back_unit.md
Name: write_back_unit

Overview:
Registered, parametrised write-back stage for the RISC-V pipeline. It selects one of four result sources (ALU, load data, PC+4, CSR) and aligns and sign/zero-extends load data by size and byte offset. Loads whose data-cache response arrives late are held with a valid/ready handshake and a stall. It drives the register-file write port with one-cycle latency, plus a forwarding copy of the written value.

Parameters:
DATA_WIDTH, 32, datapath width; legal values 32 or 64.
REG_ADDR_WIDTH, 5, register index width.
OFFSET_WIDTH, $clog2(DATA_WIDTH/8), byte-offset bits taken from the address (derived; do not override).

Ports:
CLK  in  1  clock; all state updates on the rising edge.
RST  in  1  reset, asynchronous, active-high.
IN_VALID  in  1  MEM stage presents an instruction.
IN_READY  out  1  unit can accept; equals (state==IDLE).
ALU_OUT_IN  in  DATA_WIDTH  ALU result; for loads, the effective address.
PC_PLUS_4_IN  in  DATA_WIDTH  link value for JAL/JALR.
CSR_DATA_IN  in  DATA_WIDTH  CSR read value.
WB_SELECT_IN  in  2  source select: 0 ALU, 1 LOAD, 2 PC+4, 3 CSR.
LOAD_SIZE_IN  in  2  0 byte, 1 half, 2 word, 3 double (legal only when DATA_WIDTH=64).
LOAD_UNSIGNED_IN  in  1  1 = zero-extend, 0 = sign-extend.
REG_WRITE_IN  in  1  instruction writes rd.
RD_ADDR_IN  in  REG_ADDR_WIDTH  destination register.
DATA_CACHE_OUT_DATA  in  DATA_WIDTH  raw aligned-word data from the data cache.
DATA_CACHE_READY  in  1  DATA_CACHE_OUT_DATA is valid this cycle.
REG_WRITE_EN_OUT  out  1  register-file write strobe (one-cycle pulse).
RD_ADDR_OUT  out  REG_ADDR_WIDTH  register-file write address.
RD_DATA_OUT  out  DATA_WIDTH  register-file write data; also the forwarding value.
STALL_OUT  out  1  freeze upstream stages.
MISALIGNED_OUT  out  1  one-cycle pulse on a misaligned load.

Behaviour:
- Reset: state=IDLE; all registered outputs are 0; captured fields are cleared. Reset asserted during WAIT_LOAD drops the pending load, and no write occurs.
- FSM states:
  - IDLE: IN_READY=1.
  - WAIT_LOAD: IN_READY=0.
- Accept condition: IN_VALID && IN_READY. Inputs are sampled only on accept. In WAIT_LOAD the unit uses its captured copies.
- Non-load accept, or load accept with DATA_CACHE_READY=1 in the same cycle: the result is registered at the next edge (latency 1). The unit stays in IDLE.
- Load accept with DATA_CACHE_READY=0: capture offset, size, unsigned flag, rd and REG_WRITE, then go to WAIT_LOAD.
- WAIT_LOAD with DATA_CACHE_READY=1: register the aligned result and return to IDLE. Back-to-back accept becomes possible the following cycle.
- STALL_OUT (combinational) = (state==WAIT_LOAD) || (IDLE && IN_VALID && WB_SELECT_IN==1 && !DATA_CACHE_READY).
- Write strobe: REG_WRITE_EN_OUT=1 for exactly one cycle per completed instruction when REG_WRITE is set and rd!=0. Writes to x0 are suppressed (strobe 0). RD_ADDR_OUT and RD_DATA_OUT still update.
- Output hold: RD_ADDR_OUT and RD_DATA_OUT hold their last value between completions.
- Load alignment: offset = ALU_OUT_IN[OFFSET_WIDTH-1:0]. Extract the byte/half/word/double at byte lane offset, then extend to DATA_WIDTH per LOAD_UNSIGNED. A word load on 32-bit, or a double load on 64-bit, is passed through unchanged.
- Misaligned load: half with odd offset; word with offset not a multiple of 4; double with nonzero offset; or size 3 when DATA_WIDTH=32.
  - Effect: MISALIGNED_OUT pulses 1 in the completion cycle; REG_WRITE_EN_OUT=0.
  - Completion still requires DATA_CACHE_READY (no early exit).
- WB_SELECT 0/2/3: the source is passed unmodified; LOAD_SIZE and LOAD_UNSIGNED are ignored.
- IN_VALID=0 in IDLE: no state change; strobes stay 0.

Decomposition:
- Shared package wb_pkg:
  - WB_SEL_ALU/LOAD/PC4/CSR encodings.
  - LOAD_BYTE/HALF/WORD/DOUBLE encodings.
  - FSM state enum {IDLE, WAIT_LOAD}.
- One combinational sub-module, load_aligner (DATA_WIDTH param).
  - Inputs: raw data, offset, size, unsigned.
  - Outputs: extended data, misaligned flag.
- FSM, capture registers and output registers live in write_back_unit.

Test Plan:
- ALU op, ALU_OUT_IN=0x0000_1234, rd=5, REG_WRITE=1 -> next cycle EN=1, RD_ADDR_OUT=5, RD_DATA_OUT=0x0000_1234, STALL_OUT=0 throughout.
- LB, addr offset 3, cache data 0x80FF_0000 ready same cycle, signed -> RD_DATA_OUT=0xFFFF_FF80; same with LBU -> 0x0000_0080.
- LH offset 2, cache ready 3 cycles late with data 0x8001_0000 -> STALL_OUT=1 for 3 cycles, IN_READY=0, then RD_DATA_OUT=0xFFFF_8001 with EN pulse, then IN_READY=1.
- LW offset 1, cache ready -> MISALIGNED_OUT=1 one cycle, EN=0.
- JAL with rd=0, PC_PLUS_4_IN=0x104 -> EN=0, RD_DATA_OUT=0x104; CSR select with rd=7, CSR_DATA_IN=0xDEAD_BEEF -> EN=1, RD_DATA_OUT=0xDEAD_BEEF.
- Load pending in WAIT_LOAD, assert RST for 1 cycle, then DATA_CACHE_READY=1 -> no EN pulse, all outputs 0, IN_READY=1.
